// File: rtl/traffic_phase_scheduler.sv
// rtl/traffic_phase_scheduler.sv - two-street traffic light phase scheduler with optional pedestrian walk
//
// Purpose: sequences street A / street B greens with yellow and all-red
// clearance, rest-in-green when the cross street has no demand, and min/max
// green timing under opposing demand. All timers advance on the tick strobe.
//
// Optional feature macro: PED_REQ_EN (pedestrian request, WALK phase, ped_ack).
// Without it ped_req is ignored and walk/ped_ack are held low.
//
// Ports:
//   clk      in   single clock, rising edge
//   reset    in   synchronous active-low reset
//   tick     in   timebase strobe, one clk wide
//   sense_a  in   vehicle present on street A (level)
//   sense_b  in   vehicle present on street B (level)
//   ped_req  in   pedestrian request, sampled every clk
//   ped_ack  out  one-clk pulse when the walk phase starts
//   la, lb   out  street lights: red=00, yellow=01, green=10
//   walk     out  pedestrian walk signal
//   phase    out  current state code
module traffic_phase_scheduler #(
    parameter int GREEN_MIN = 8,
    parameter int GREEN_MAX = 30,
    parameter int YELLOW_T  = 3,
    parameter int ALLRED_T  = 1,
    parameter int WALK_T    = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       sense_a,
    input  logic       sense_b,
    input  logic       ped_req,
    output logic       ped_ack,
    output logic [1:0] la,
    output logic [1:0] lb,
    output logic       walk,
    output logic [2:0] phase
);

    typedef enum logic [2:0] {
        A_GRN = 3'b000,
        A_YEL = 3'b001,
        AR_AB = 3'b010,
        B_GRN = 3'b011,
        B_YEL = 3'b100,
        AR_BA = 3'b101,
        WALK  = 3'b110
    } state_t;

    localparam logic [7:0] GMIN_M1 = 8'(GREEN_MIN - 1);
    localparam logic [7:0] GMAX_M1 = 8'(GREEN_MAX - 1);
    localparam logic [7:0] YEL_M1  = 8'(YELLOW_T - 1);
    localparam logic [7:0] AR_M1   = 8'(ALLRED_T - 1);
    localparam logic [7:0] WALK_M1 = 8'(WALK_T - 1);

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       next_b_q, next_b_d;
    logic       ped_pending;
    logic       demand_a, demand_b;
    logic       is_green;

    assign demand_a = sense_a | ped_pending;
    assign demand_b = sense_b | ped_pending;
    assign is_green = (state_q == A_GRN) || (state_q == B_GRN);

    always_comb begin
        state_d  = state_q;
        next_b_d = next_b_q;
        case (state_q)
            A_GRN: if (tick && demand_b &&
                       ((cnt_q >= GMAX_M1) || ((cnt_q >= GMIN_M1) && !sense_a)))
                       state_d = A_YEL;
            A_YEL: if (tick && (cnt_q == YEL_M1)) state_d = AR_AB;
            AR_AB: if (tick && (cnt_q == AR_M1)) begin
                       if (ped_pending) begin
                           state_d  = WALK;
                           next_b_d = 1'b1;   // B has not been served yet
                       end else begin
                           state_d  = B_GRN;
                       end
                   end
            B_GRN: if (tick && demand_a &&
                       ((cnt_q >= GMAX_M1) || ((cnt_q >= GMIN_M1) && !sense_b)))
                       state_d = B_YEL;
            B_YEL: if (tick && (cnt_q == YEL_M1)) state_d = AR_BA;
            AR_BA: if (tick && (cnt_q == AR_M1)) begin
                       if (ped_pending) begin
                           state_d  = WALK;
                           next_b_d = 1'b0;
                       end else begin
                           state_d  = A_GRN;
                       end
                   end
            WALK:  if (tick && (cnt_q == WALK_M1))
                       state_d = next_b_q ? B_GRN : A_GRN;
            default: state_d = A_GRN;
        endcase
    end

    // Counter restarts on every state entry; greens hold at GREEN_MAX-1 so
    // a long rest cannot wrap and fake a short green.
    always_comb begin
        cnt_d = cnt_q;
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (tick) begin
            if (is_green && (cnt_q >= GMAX_M1)) cnt_d = cnt_q;
            else                                cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= A_GRN;
            cnt_q    <= '0;
            next_b_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            next_b_q <= next_b_d;
        end
    end

`ifdef PED_REQ_EN
    logic ped_pending_q, ped_pending_d;
    logic ped_ack_q;
    logic enter_walk;

    assign enter_walk = (state_d == WALK) && (state_q != WALK);
    // A request arriving on the entry edge is kept for the next cycle.
    assign ped_pending_d = enter_walk ? ped_req : (ped_pending_q | ped_req);

    always_ff @(posedge clk) begin
        if (!reset) begin
            ped_pending_q <= 1'b0;
            ped_ack_q     <= 1'b0;
        end else begin
            ped_pending_q <= ped_pending_d;
            ped_ack_q     <= enter_walk;
        end
    end

    assign ped_pending = ped_pending_q;
    assign ped_ack     = ped_ack_q;
    assign walk        = (state_q == WALK);
`else
    logic unused_ped_req;
    assign unused_ped_req = ped_req;
    assign ped_pending    = 1'b0;
    assign ped_ack        = 1'b0;
    assign walk           = 1'b0;
`endif

    always_comb begin
        la = 2'b00;
        lb = 2'b00;
        case (state_q)
            A_GRN:   la = 2'b10;
            A_YEL:   la = 2'b01;
            B_GRN:   lb = 2'b10;
            B_YEL:   lb = 2'b01;
            default: begin
                la = 2'b00;
                lb = 2'b00;
            end
        endcase
    end

    assign phase = state_q;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// tb/tb_traffic_phase_scheduler.sv - self-checking bench for traffic_phase_scheduler
`timescale 1ns/1ps
module tb_traffic_phase_scheduler;

    localparam int GMIN = 4;
    localparam int GMAX = 10;
    localparam int YEL  = 2;
    localparam int ART  = 1;
    localparam int WLK  = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       tick = 1'b0;
    logic       sense_a = 1'b0;
    logic       sense_b = 1'b0;
    logic       ped_req = 1'b0;
    logic       ped_ack;
    logic [1:0] la;
    logic [1:0] lb;
    logic       walk;
    logic [2:0] phase;

    always #5 clk = ~clk;

    traffic_phase_scheduler #(
        .GREEN_MIN(GMIN),
        .GREEN_MAX(GMAX),
        .YELLOW_T (YEL),
        .ALLRED_T (ART),
        .WALK_T   (WLK)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .tick   (tick),
        .sense_a(sense_a),
        .sense_b(sense_b),
        .ped_req(ped_req),
        .ped_ack(ped_ack),
        .la     (la),
        .lb     (lb),
        .walk   (walk),
        .phase  (phase)
    );

    // One table row: hold sensors for n ticks, expecting phase ph after each.
    typedef struct {
        logic       sa;
        logic       sb;
        logic [2:0] ph;
        int         n;
        int         ack;
    } seg_t;

    typedef struct {
        logic [2:0] ph;
        logic [1:0] la;
        logic [1:0] lb;
        logic       wk;
        int         ack;
    } exp_t;

    seg_t tbl[$];
    exp_t sb_q[$];
    int   checks = 0;
    int   passes = 0;
    int   clk_n = 0;
    bit   ped_pulse_en = 1'b0;
    logic [2:0] last_ph = 3'd0;

    task automatic check(string name, int act, int req);
        checks++;
        if (act == req) passes++;
        else $display("FAIL %s: got %0d, required %0d", name, act, req);
    endtask

    function automatic exp_t mk(logic [2:0] ph, int ack);
        exp_t e;
        e.ph  = ph;
        e.ack = ack;
        e.wk  = (ph == 3'd6);
        e.la  = 2'b00;
        e.lb  = 2'b00;
        case (ph)
            3'd0: e.la = 2'b10;
            3'd1: e.la = 2'b01;
            3'd3: e.lb = 2'b10;
            3'd4: e.lb = 2'b01;
            default: ;
        endcase
        return e;
    endfunction

    task automatic one_clk(logic t, inout int acks);
        tick    = t;
        ped_req = ped_pulse_en && (clk_n % 5 == 0);
        @(posedge clk);
        clk_n++;
        @(negedge clk);
        if (ped_ack) acks++;
    endtask

    task automatic step(logic sa, logic sb, logic [2:0] ph, int ack, string tag);
        exp_t e;
        int   acks = 0;
        sense_a = sa;
        sense_b = sb;
        sb_q.push_back(mk(ph, ack));
        for (int i = 0; i < 3; i++) one_clk(1'b0, acks);
        check({tag, " hold"}, int'(phase), int'(last_ph));
        one_clk(1'b1, acks);
        tick    = 1'b0;
        ped_req = 1'b0;
        e = sb_q.pop_front();
        check({tag, " phase"}, int'(phase), int'(e.ph));
        check({tag, " la"},    int'(la),    int'(e.la));
        check({tag, " lb"},    int'(lb),    int'(e.lb));
        check({tag, " walk"},  int'(walk),  int'(e.wk));
        check({tag, " ack"},   acks,        e.ack);
        last_ph = e.ph;
    endtask

    task automatic run_table(string tag);
        for (int s = 0; s < tbl.size(); s++)
            for (int k = 0; k < tbl[s].n; k++)
                step(tbl[s].sa, tbl[s].sb, tbl[s].ph, tbl[s].ack, tag);
        tbl.delete();
    endtask

    task automatic add(logic sa, logic sb, logic [2:0] ph, int n, int ack = 0);
        seg_t s;
        s.sa = sa; s.sb = sb; s.ph = ph; s.n = n; s.ack = ack;
        tbl.push_back(s);
    endtask

    task automatic apply_reset(string tag);
        reset   = 1'b0;
        tick    = 1'b0;
        sense_a = 1'b0;
        sense_b = 1'b0;
        ped_req = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check({tag, " rst phase"}, int'(phase),   0);
        check({tag, " rst la"},    int'(la),      2);
        check({tag, " rst lb"},    int'(lb),      0);
        check({tag, " rst walk"},  int'(walk),    0);
        check({tag, " rst ack"},   int'(ped_ack), 0);
        reset   = 1'b1;
        last_ph = 3'd0;
    endtask

    initial begin
        int acks;

        // Rest in A green with no demand.
        apply_reset("idle");
        add(0, 0, 3'd0, 50);
        run_table("idle");

        // B demand only: min green, yellow, all-red, B rests; then A demand.
        apply_reset("bdem");
        add(0, 1, 3'd0, 3);
        add(0, 1, 3'd1, 2);
        add(0, 1, 3'd2, 1);
        add(0, 1, 3'd3, 3);
        add(1, 0, 3'd3, 1);
        add(1, 0, 3'd4, 2);
        add(1, 0, 3'd5, 1);
        add(1, 0, 3'd0, 2);
        run_table("bdem");

        // Constant demand on both: greens run to max (10 ticks).
        apply_reset("both");
        add(1, 1, 3'd0, 9);
        add(1, 1, 3'd1, 2);
        add(1, 1, 3'd2, 1);
        add(1, 1, 3'd3, 10);
        add(1, 1, 3'd4, 2);
        add(1, 1, 3'd5, 1);
        add(1, 1, 3'd0, 10);
        add(1, 1, 3'd1, 1);
        run_table("both");

        // Reset while in B yellow, on the same clk as a tick.
        apply_reset("yrst");
        add(0, 1, 3'd0, 3);
        add(0, 1, 3'd1, 2);
        add(0, 1, 3'd2, 1);
        add(0, 1, 3'd3, 3);
        add(1, 0, 3'd3, 1);
        add(1, 0, 3'd4, 1);
        run_table("yrst");
        acks = 0;
        for (int i = 0; i < 3; i++) one_clk(1'b0, acks);
        reset = 1'b0;
        one_clk(1'b1, acks);
        tick = 1'b0;
        check("yrst mid phase", int'(phase), 0);
        check("yrst mid la",    int'(la),    2);
        check("yrst mid lb",    int'(lb),    0);
        reset   = 1'b1;
        last_ph = 3'd0;
        add(0, 1, 3'd0, 3);
        add(0, 1, 3'd1, 1);
        run_table("yrst post");

`ifdef PED_REQ_EN
        // One-clk pedestrian request in A green with no vehicles.
        apply_reset("ped");
        ped_req = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ped_req = 1'b0;
        add(0, 0, 3'd0, 3);
        add(0, 0, 3'd1, 2);
        add(0, 0, 3'd2, 1);
        add(0, 0, 3'd6, 1, 1);
        add(0, 0, 3'd6, 2);
        add(0, 0, 3'd3, 3);
        run_table("ped");
`else
        // Pedestrian requests must be ignored in this build.
        apply_reset("noped");
        ped_pulse_en = 1'b1;
        add(0, 0, 3'd0, 20);
        run_table("noped");
        ped_pulse_en = 1'b0;
`endif

        check("scoreboard drained", sb_q.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
